// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT sample width, complex sample type and frame helpers.
package fft_pkg;
  localparam int W = 32;
  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] img;
  } cplx_t;
  function automatic int frame_len(input int d);
    return 2 * d;
  endfunction
  function automatic int cnt_w(input int d);
    return $clog2(2 * d);
  endfunction
endpackage

// File: rtl/sdf_delay_line.sv
// sdf_delay_line: D-deep complex shift register, advances only when en is high.
module sdf_delay_line #(
  parameter int W = fft_pkg::W,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_img,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_img
);
  logic [W-1:0] re_q [D];
  logic [W-1:0] img_q [D];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) begin
        re_q[i]  <= '0;
        img_q[i] <= '0;
      end
    end else if (en) begin
      re_q[0]  <= in_re;
      img_q[0] <= in_img;
      for (int i = 1; i < D; i++) begin
        re_q[i]  <= re_q[i-1];
        img_q[i] <= img_q[i-1];
      end
    end
  end
  assign out_re  = re_q[D-1];
  assign out_img = img_q[D-1];
endmodule

// File: rtl/r2_sdf_stage.sv
// r2_sdf_stage: radix-2 single-path delay-feedback butterfly stage.
module r2_sdf_stage
  import fft_pkg::*;
#(
  parameter int W     = fft_pkg::W,
  parameter int D     = 8,
  parameter int SCALE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_img,
  output logic         out_valid,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_img,
  output logic         out_diff
);
  localparam int CW = cnt_w(D);
  localparam int FL = frame_len(D);
  logic [CW-1:0] cnt;
  logic          pend, phase_b, last;
  logic [W-1:0]  h_re, h_img, l_re, l_img, o_re, o_img;
  logic [W:0]    s_re, s_img, d_re, d_img;
  function automatic logic [W-1:0] scl(input logic [W:0] v);
    return SCALE != 0 ? v[W:1] : v[W-1:0];
  endfunction
  sdf_delay_line #(.W(W), .D(D)) u_line (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (in_valid),
    .in_re  (l_re),
    .in_img (l_img),
    .out_re (h_re),
    .out_img(h_img)
  );
  always_comb begin
    phase_b = cnt >= CW'(D);
    last    = cnt == CW'(FL - 1);
    s_re    = {h_re[W-1], h_re} + {in_re[W-1], in_re};
    s_img   = {h_img[W-1], h_img} + {in_img[W-1], in_img};
    d_re    = {h_re[W-1], h_re} - {in_re[W-1], in_re};
    d_img   = {h_img[W-1], h_img} - {in_img[W-1], in_img};
    l_re    = phase_b ? scl(d_re) : in_re;
    l_img   = phase_b ? scl(d_img) : in_img;
    o_re    = phase_b ? scl(s_re) : h_re;
    o_img   = phase_b ? scl(s_img) : h_img;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      pend      <= 1'b0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_img   <= '0;
      out_diff  <= 1'b0;
    end else begin
      out_valid <= in_valid & (phase_b | pend);
      if (in_valid) begin
        cnt      <= last ? '0 : cnt + 1'b1;
        pend     <= pend | last;
        out_re   <= o_re;
        out_img  <= o_img;
        out_diff <= ~phase_b;
      end
    end
  end
endmodule

// File: tb/tb_r2_sdf_stage.sv
// tb_r2_sdf_stage: directed vector bench for r2_sdf_stage, SCALE=0 and SCALE=1 side by side.
module tb_r2_sdf_stage;
  typedef struct {
    bit          v;
    logic [31:0] re, img;
    bit          ev, cd;
    logic [31:0] r0, r1, i0, i1;
    bit          ed;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n, in_valid;
  logic [31:0] in_re, in_img;
  logic        ov0, od0, ov1, od1;
  logic [31:0] ore0, oi0, ore1, oi1;
  int          n_chk = 0, n_pass = 0;
  vec_t        tv [40];
  always #5 clk = ~clk;
  r2_sdf_stage #(.W(32), .D(8), .SCALE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_re(in_re), .in_img(in_img),
    .out_valid(ov0), .out_re(ore0), .out_img(oi0), .out_diff(od0)
  );
  r2_sdf_stage #(.W(32), .D(8), .SCALE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_re(in_re), .in_img(in_img),
    .out_valid(ov1), .out_re(ore1), .out_img(oi1), .out_diff(od1)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic step(input bit v, input logic [31:0] re, input logic [31:0] img);
    @(negedge clk);
    in_valid = v;
    in_re    = re;
    in_img   = img;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #2;
    chk("rst_valid0", {31'd0, ov0}, 32'd0);
    chk("rst_valid1", {31'd0, ov1}, 32'd0);
    chk("rst_re0", ore0, 32'd0);
    chk("rst_re1", ore1, 32'd0);
    chk("rst_img0", oi0, 32'd0);
    chk("rst_diff0", {31'd0, od0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  function automatic vec_t mk(input bit v, input logic [31:0] re, input logic [31:0] img,
                              input bit ev, input bit cd, input logic [31:0] r0, input logic [31:0] r1,
                              input logic [31:0] i0, input logic [31:0] i1, input bit ed);
    vec_t t;
    t.v = v; t.re = re; t.img = img; t.ev = ev; t.cd = cd;
    t.r0 = r0; t.r1 = r1; t.i0 = i0; t.i1 = i1; t.ed = ed;
    return t;
  endfunction
  task automatic run_ramp(input bit gap);
    logic [31:0] held;
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 32'(k), 32'd0);
      chk($sformatf("ramp_v0_%0d", k), {31'd0, ov0}, {31'd0, k > 8});
      chk($sformatf("ramp_v1_%0d", k), {31'd0, ov1}, {31'd0, k > 8});
      if (k > 8) begin
        chk($sformatf("ramp_sum0_%0d", k), ore0, 32'(2 * k - 8));
        chk($sformatf("ramp_sum1_%0d", k), ore1, 32'(k - 4));
        chk($sformatf("ramp_sdiff_%0d", k), {31'd0, od0}, 32'd0);
      end
      if (gap) begin
        held = ore0;
        step(1'b0, 32'hdead_beef, 32'hdead_beef);
        chk($sformatf("gap_v_%0d", k), {31'd0, ov0}, 32'd0);
        chk($sformatf("gap_hold_%0d", k), ore0, held);
      end
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 32'd0, 32'd0);
      chk($sformatf("flush_v_%0d", k), {31'd0, ov0}, 32'd1);
      chk($sformatf("flush_d0_%0d", k), ore0, -32'sd8);
      chk($sformatf("flush_d1_%0d", k), ore1, -32'sd4);
      chk($sformatf("flush_flag_%0d", k), {31'd0, od0}, 32'd1);
      if (gap) begin
        step(1'b0, 32'd0, 32'd0);
        chk($sformatf("fgap_v_%0d", k), {31'd0, ov1}, 32'd0);
      end
    end
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_re = '0; in_img = '0;
    for (int k = 0; k < 16; k++)
      tv[k] = (k < 8) ? mk(1, 32'(k + 1), 0, 0, 0, 0, 0, 0, 0, 0)
                      : mk(1, 32'(k + 1), 0, 1, 1, 32'(2 * k - 6), 32'(k - 3), 0, 0, 0);
    for (int j = 0; j < 8; j++) begin
      tv[16 + j] = mk(1, j == 0 ? 32'h7FFF_FFFF : 32'd0, j == 1 ? -32'sd3 : 32'd0,
                      1, 1, -32'sd8, -32'sd4, 0, 0, 1);
      tv[24 + j] = mk(1, j == 0 ? 32'd1 : 32'd0, j == 1 ? 32'd5 : 32'd0, 1, 1,
                      j == 0 ? 32'h8000_0000 : 32'd0, j == 0 ? 32'h4000_0000 : 32'd0,
                      j == 1 ? 32'd2 : 32'd0, j == 1 ? 32'd1 : 32'd0, 0);
      tv[32 + j] = mk(1, 0, 0, 1, 1,
                      j == 0 ? 32'h7FFF_FFFE : 32'd0, j == 0 ? 32'h3FFF_FFFF : 32'd0,
                      j == 1 ? -32'sd8 : 32'd0, j == 1 ? -32'sd4 : 32'd0, 1);
    end
    do_reset();
    for (int k = 0; k < 40; k++) begin
      step(tv[k].v, tv[k].re, tv[k].img);
      chk($sformatf("tv%0d_v0", k), {31'd0, ov0}, {31'd0, tv[k].ev});
      chk($sformatf("tv%0d_v1", k), {31'd0, ov1}, {31'd0, tv[k].ev});
      if (tv[k].cd) begin
        chk($sformatf("tv%0d_re0", k), ore0, tv[k].r0);
        chk($sformatf("tv%0d_re1", k), ore1, tv[k].r1);
        chk($sformatf("tv%0d_img0", k), oi0, tv[k].i0);
        chk($sformatf("tv%0d_img1", k), oi1, tv[k].i1);
        chk($sformatf("tv%0d_diff0", k), {31'd0, od0}, {31'd0, tv[k].ed});
        chk($sformatf("tv%0d_diff1", k), {31'd0, od1}, {31'd0, tv[k].ed});
      end
    end
    do_reset();
    run_ramp(1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 32'd100, 32'd0);
      chk($sformatf("pre_rst_v_%0d", k), {31'd0, ov0}, 32'd1);
      chk($sformatf("pre_rst_re_%0d", k), ore0, 32'd100);
    end
    do_reset();
    run_ramp(1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
